calc_rr_scheduler: RTL and testbench

- Round-robin scheduler that shares one multi-cycle calculator ALU among NREQ requesters.
- The ALU supports the ops add, sub, mul, div, and, or, shl, shr.
- The scheduler accepts one operation per requester handshake, launches it on the ALU, waits for completion, and returns the result tagged with the requester id.
- It sits between the command front-ends and the single shared ALU instance.

---
 rtl/calc_rr_scheduler.sv | 239 +++++++++++++++++++++++
 tb/tb_calc_rr_scheduler.sv | 495 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/calc_rr_scheduler.sv
// calc_rr_scheduler
// Shares one multi-cycle calculator ALU among NREQ requesters. A round-robin
// arbiter picks one request while idle. The scheduler launches that request on
// the ALU, waits for completion and returns the result tagged with the id of
// the requester. Only one operation is in flight at a time.
//
// A divide by zero is answered at once with rsp_err=1 and the ALU is not
// launched.
//
// Optional feature: define CALC_RR_SCHED_TIMEOUT_EN to add a watchdog. With
// it, a BUSY phase that lasts TIMEOUT cycles without alu_done is answered with
// rsp_result=0 and rsp_err=1.
module calc_rr_scheduler #(
  parameter int NREQ    = 4,
  parameter int W       = 32,
  parameter int TIMEOUT = 64
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NREQ-1:0]         req_valid,
  output logic [NREQ-1:0]         req_ready,
  input  logic [NREQ*W-1:0]       req_a,
  input  logic [NREQ*W-1:0]       req_b,
  input  logic [NREQ*3-1:0]       req_op,
  output logic                    alu_start,
  output logic [W-1:0]            alu_a,
  output logic [W-1:0]            alu_b,
  output logic [2:0]              alu_op,
  input  logic                    alu_done,
  input  logic [W-1:0]            alu_result,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [$clog2(NREQ)-1:0] rsp_id,
  output logic [W-1:0]            rsp_result,
  output logic                    rsp_err
);

  localparam int         IdW   = $clog2(NREQ);
  localparam logic [2:0] OpDiv = 3'd3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    BUSY  = 2'd2,
    RESP  = 2'd3
  } state_e;

  state_e         state_q, state_d;
  logic [IdW-1:0] last_q, last_d;
  logic [IdW-1:0] id_q, id_d;
  logic [W-1:0]   a_q, a_d;
  logic [W-1:0]   b_q, b_d;
  logic [2:0]     op_q, op_d;
  logic [W-1:0]   result_q, result_d;
  logic           err_q, err_d;

  // Arbitration results and the operands of the winning requester.
  logic           hi_found, lo_found, grant_found;
  logic [IdW-1:0] hi_id, lo_id, grant_id;
  logic [W-1:0]   sel_a, sel_b;
  logic [2:0]     sel_op;
  logic           sel_dz;
  logic           xfer;
  logic           timeout_hit;

  // Round-robin search. Requesters above last are tried first, in ascending
  // order, then the search wraps to those at or below last. This is the same
  // order as scanning from last+1 modulo NREQ.
  always_comb begin
    // NOTE: every signal written here gets a default value first. Without the
    // default, a path that skips an assignment would infer a latch.
    hi_found = 1'b0;
    hi_id    = '0;
    lo_found = 1'b0;
    lo_id    = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (!hi_found && req_valid[i] && (i > int'(last_q))) begin
        hi_found = 1'b1;
        hi_id    = IdW'(i);
      end
    end
    for (int i = 0; i < NREQ; i++) begin
      if (!lo_found && req_valid[i] && (i <= int'(last_q))) begin
        lo_found = 1'b1;
        lo_id    = IdW'(i);
      end
    end
    grant_found = hi_found | lo_found;
    grant_id    = hi_found ? hi_id : lo_id;
  end

  // Operand mux for the winner. The loop index is constant per slice.
  always_comb begin
    sel_a  = '0;
    sel_b  = '0;
    sel_op = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant_id == IdW'(i)) begin
        sel_a  = req_a[i*W +: W];
        sel_b  = req_b[i*W +: W];
        sel_op = req_op[i*3 +: 3];
      end
    end
  end

  assign sel_dz = (sel_op == OpDiv) && (sel_b == '0);

  // A grant is offered only while idle and out of reset. This keeps
  // req_ready at zero while rst_n is low, even with req_valid bits set.
  assign xfer = rst_n && (state_q == IDLE) && grant_found;

  // One-hot ready to the round-robin winner.
  always_comb begin
    req_ready = '0;
    if (xfer) begin
      req_ready[grant_id] = 1'b1;
    end
  end

`ifdef CALC_RR_SCHED_TIMEOUT_EN
  localparam int CntW = $clog2(TIMEOUT + 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  // Watchdog count. It clears in ISSUE, so it is zero on the first BUSY
  // cycle, and it advances once per BUSY cycle.
  always_comb begin
    cnt_d = cnt_q;
    if (state_q == ISSUE) begin
      cnt_d = '0;
    end else if (state_q == BUSY) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Watchdog register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Fires on the last of TIMEOUT BUSY cycles. alu_done in that same cycle wins.
  assign timeout_hit = (state_q == BUSY) && !alu_done &&
                       (cnt_q == CntW'(TIMEOUT - 1));
`else
  // Without the watchdog, BUSY waits for alu_done indefinitely.
  logic timeout_unused;
  assign timeout_unused = (TIMEOUT != 0);
  assign timeout_hit    = 1'b0;
`endif

  // Next-state logic of the scheduling FSM.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (xfer) state_d = sel_dz ? RESP : ISSUE;
      ISSUE:   state_d = BUSY;
      BUSY:    if (alu_done || timeout_hit) state_d = RESP;
      RESP:    if (rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath next-state logic. A transfer latches the request. A completion
  // in BUSY latches the answer. Everything else holds.
  always_comb begin
    last_d   = last_q;
    id_d     = id_q;
    a_d      = a_q;
    b_d      = b_q;
    op_d     = op_q;
    result_d = result_q;
    err_d    = err_q;
    if (xfer) begin
      last_d = grant_id;
      id_d   = grant_id;
      a_d    = sel_a;
      b_d    = sel_b;
      op_d   = sel_op;
      if (sel_dz) begin
        result_d = '0;
        err_d    = 1'b1;
      end
    end
    if (state_q == BUSY) begin
      if (alu_done) begin
        result_d = alu_result;
        err_d    = 1'b0;
      end else if (timeout_hit) begin
        result_d = '0;
        err_d    = 1'b1;
      end
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: the datapath registers are reset along with the FSM. Every output
    // is a register value, and all outputs must read zero out of reset.
    if (!rst_n) begin
      state_q  <= IDLE;
      last_q   <= IdW'(NREQ - 1);
      id_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      op_q     <= '0;
      result_q <= '0;
      err_q    <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments, so every
      // register samples the values from before this edge.
      state_q  <= state_d;
      last_q   <= last_d;
      id_q     <= id_d;
      a_q      <= a_d;
      b_q      <= b_d;
      op_q     <= op_d;
      result_q <= result_d;
      err_q    <= err_d;
    end
  end

  // Output decode. The strobes come from the state, and the data comes from
  // the latched registers.
  always_comb begin
    alu_start  = (state_q == ISSUE);
    rsp_valid  = (state_q == RESP);
    alu_a      = a_q;
    alu_b      = b_q;
    alu_op     = op_q;
    rsp_id     = id_q;
    rsp_result = result_q;
    rsp_err    = err_q;
  end

endmodule

// File: tb/tb_calc_rr_scheduler.sv
// tb_calc_rr_scheduler
// Self-checking bench for calc_rr_scheduler. A transaction-level model checks
// every cycle: it tracks the op in flight by its grant and completion cycle
// numbers. Directed scenarios pin the model with literal values, then a
// randomized phase runs with a reactive ALU model. Define
// CALC_RR_SCHED_TIMEOUT_EN to also exercise the watchdog (TIMEOUT=8).
module tb_calc_rr_scheduler;

  localparam int NREQ = 4;
  localparam int W    = 32;
  localparam int TOUT = 8;
  localparam int IdW  = $clog2(NREQ);

  logic                clk;
  logic                rst_n;
  logic [NREQ-1:0]     req_valid;
  logic [NREQ-1:0]     req_ready;
  logic [NREQ*W-1:0]   req_a;
  logic [NREQ*W-1:0]   req_b;
  logic [NREQ*3-1:0]   req_op;
  logic                alu_start;
  logic [W-1:0]        alu_a;
  logic [W-1:0]        alu_b;
  logic [2:0]          alu_op;
  logic                alu_done;
  logic [W-1:0]        alu_result;
  logic                rsp_valid;
  logic                rsp_ready;
  logic [IdW-1:0]      rsp_id;
  logic [W-1:0]        rsp_result;
  logic                rsp_err;

  int n_checks = 0;
  int n_err    = 0;
  int n_rsp    = 0;

  // ALU model controls. Only the main sequence writes these.
  int lat_fixed   = 0;
  bit drop_done   = 0;
  bit spurious_en = 0;
  int inj_req     = 0;
  int inj_seen    = 0;

  calc_rr_scheduler #(.NREQ(NREQ), .W(W), .TIMEOUT(TOUT)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_a      (req_a),
    .req_b      (req_b),
    .req_op     (req_op),
    .alu_start  (alu_start),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_op     (alu_op),
    .alu_done   (alu_done),
    .alu_result (alu_result),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_id     (rsp_id),
    .rsp_result (rsp_result),
    .rsp_err    (rsp_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [W-1:0] alu_ref(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic [2:0] op);
    case (op)
      3'd0:    return a + b;
      3'd1:    return a - b;
      3'd2:    return a * b;
      3'd3:    return (b == '0) ? '0 : a / b;
      3'd4:    return a & b;
      3'd5:    return a | b;
      3'd6:    return a << b[4:0];
      default: return a >> b[4:0];
    endcase
  endfunction

  // Reactive ALU. After alu_start it answers with the latency that
  // lat_fixed selects (random when lat_fixed is 0). The result is computed
  // from alu_a/alu_b/alu_op as they are when the answer is given. While no
  // op is pending it may pulse alu_done spuriously.
  initial begin
    int  cnt;
    bit  pend;
    pend       = 1'b0;
    cnt        = 0;
    alu_done   = 1'b0;
    alu_result = '0;
    forever begin
      @(posedge clk);
      #1;
      alu_done   = 1'b0;
      alu_result = $urandom;
      if (!rst_n) begin
        pend = 1'b0;
      end else if (inj_req != inj_seen) begin
        inj_seen = inj_req;
        alu_done = 1'b1;
      end else if (pend) begin
        cnt--;
        if (cnt == 0) begin
          pend       = 1'b0;
          alu_done   = 1'b1;
          alu_result = alu_ref(alu_a, alu_b, alu_op);
        end
      end else if (alu_start && !drop_done) begin
        pend = 1'b1;
        cnt  = (lat_fixed > 0) ? lat_fixed : $urandom_range(1, 6);
      end else if (spurious_en && !drop_done && $urandom_range(0, 7) == 0) begin
        alu_done = 1'b1;
      end
    end
  end

  // Transaction-level reference model. With no op held, the expected grant
  // is the first valid requester after m_last, scanning modulo NREQ. A held op
  // is described only by its grant cycle m_tg and its completion cycle m_td.
  // From those it follows when alu_start and rsp_valid must appear.
  int             mc = 0;
  bit             m_have = 0;
  int             m_last = NREQ - 1;
  int             m_id, m_tg, m_td;
  bit             m_dz, m_err;
  logic [W-1:0]   m_a, m_b, m_res;
  logic [2:0]     m_op;

  always @(negedge clk) begin : model_cmp
    logic [NREQ-1:0] exp_ready;
    int              win;
    bit              exp_start, exp_rsp;
    if (!rst_n) begin
      m_have = 0;
      m_last = NREQ - 1;
    end else begin
      mc++;
      exp_ready = '0;
      exp_start = 0;
      exp_rsp   = 0;
      win       = -1;
      if (!m_have) begin
        for (int k = 1; k <= NREQ; k++) begin
          if (win < 0 && req_valid[(m_last + k) % NREQ]) win = (m_last + k) % NREQ;
        end
        if (win >= 0) exp_ready[win] = 1'b1;
      end else begin
        exp_start = !m_dz && (mc == m_tg + 1);
        exp_rsp   = m_dz ? (mc >= m_tg + 1) : (m_td >= 0 && mc > m_td);
      end
      check("m_req_ready", req_ready, exp_ready);
      check("m_alu_start", alu_start, exp_start);
      check("m_rsp_valid", rsp_valid, exp_rsp);
      if (exp_rsp) begin
        check("m_rsp_id", rsp_id, m_id);
        check("m_rsp_result", rsp_result, m_res);
        check("m_rsp_err", rsp_err, m_err);
      end
      if (m_have && !m_dz && mc >= m_tg + 1 && m_td < 0) begin
        check("m_alu_a", alu_a, m_a);
        check("m_alu_b", alu_b, m_b);
        check("m_alu_op", alu_op, m_op);
      end
      // Advance the model to what the coming rising edge does.
      if (win >= 0) begin
        m_have = 1;
        m_id   = win;
        m_a    = req_a[win*W +: W];
        m_b    = req_b[win*W +: W];
        m_op   = req_op[win*3 +: 3];
        m_dz   = (m_op == 3'd3) && (m_b == '0);
        m_res  = m_dz ? '0 : alu_ref(m_a, m_b, m_op);
        m_err  = m_dz;
        m_tg   = mc;
        m_td   = -1;
        m_last = win;
      end else if (m_have) begin
        if (exp_rsp && rsp_ready) begin
          m_have = 0;
          n_rsp++;
        end else if (!m_dz && m_td < 0 && mc >= m_tg + 2) begin
          if (alu_done) m_td = mc;
`ifdef CALC_RR_SCHED_TIMEOUT_EN
          else if (mc == m_tg + 1 + TOUT) begin
            m_td  = mc;
            m_res = '0;
            m_err = 1;
          end
`endif
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [2:0] op);
    req_a[i*W +: W] = a;
    req_b[i*W +: W] = b;
    req_op[i*3 +: 3] = op;
  endtask

  // Waits, within a bound, for a grant and checks which one it is.
  // Returns at the falling edge of the grant cycle.
  task automatic wait_ready(input string nm, input logic [NREQ-1:0] exp);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (req_ready == '0 && n < 50);
    check(nm, req_ready, exp);
  endtask

  // Waits for the next response handshake, then moves past that edge.
  task automatic drain();
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(rsp_valid && rsp_ready) && n < 100);
    check("drain_handshake", rsp_valid && rsp_ready, 1'b1);
    tick();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #3;
    rst_n = 1'b1;
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin : main
    int n, starts, rdy_cnt, bad_hold, bad_ready, k;
    int ids[4];
    logic [W-1:0] res[4];

    rst_n     = 1'b1;
    req_valid = '0;
    req_a     = '0;
    req_b     = '0;
    req_op    = '0;
    rsp_ready = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_req_ready", req_ready, 0);
    check("rst_alu_start", alu_start, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_err", rsp_err, 0);
    check("rst_alu_a", alu_a, 0);
    check("rst_alu_b", alu_b, 0);
    check("rst_alu_op", alu_op, 0);
    check("rst_rsp_id", rsp_id, 0);
    check("rst_rsp_result", rsp_result, 0);
    repeat (2) @(posedge clk);
    #3;
    rst_n = 1'b1;

    // Single op: 7 + 5 from requester 1, ALU latency 3.
    tick();
    lat_fixed = 3;
    set_req(1, 7, 5, 3'd0);
    req_valid = 4'b0010;
    @(negedge clk);
    check("t1_ready", req_ready, 4'b0010);
    rdy_cnt = req_ready[1];
    starts  = 0;
    n       = 0;
    while (!rsp_valid && n < 50) begin
      @(negedge clk);
      n++;
      rdy_cnt += int'(req_ready[1]);
      if (alu_start) begin
        starts++;
        check("t1_alu_a", alu_a, 7);
        check("t1_alu_b", alu_b, 5);
      end
    end
    check("t1_latency", n, 5);
    check("t1_starts", starts, 1);
    check("t1_ready_cycles", rdy_cnt, 1);
    check("t1_rsp_id", rsp_id, 1);
    check("t1_rsp_result", rsp_result, 12);
    check("t1_rsp_err", rsp_err, 0);
    tick();
    req_valid = '0;
    rsp_ready = 1'b1;
    tick();

    // Round robin: all four requesters are valid, so they answer in id order.
    do_reset();
    lat_fixed = 2;
    set_req(0, 2, 3, 3'd2);
    set_req(1, 9, 4, 3'd1);
    set_req(2, 6, 3, 3'd4);
    set_req(3, 1, 4, 3'd6);
    req_valid = 4'b1111;
    rsp_ready = 1'b1;
    k = 0;
    n = 0;
    while (k < 4 && n < 200) begin
      @(negedge clk);
      n++;
      if (rsp_valid && rsp_ready) begin
        ids[k] = int'(rsp_id);
        res[k] = rsp_result;
        k++;
      end
    end
    check("t2_count", k, 4);
    check("t2_id0", ids[0], 0);
    check("t2_id1", ids[1], 1);
    check("t2_id2", ids[2], 2);
    check("t2_id3", ids[3], 3);
    check("t2_res0", res[0], 6);
    check("t2_res1", res[1], 5);
    check("t2_res2", res[2], 2);
    check("t2_res3", res[3], 16);
    @(negedge clk);
    check("t2_fifth_grant", req_ready, 4'b0001);
    tick();
    req_valid = '0;
    drain();

    // Divide by zero from requester 2 is answered one cycle after the transfer.
    rsp_ready = 1'b0;
    set_req(2, 10, 0, 3'd3);
    req_valid = 4'b0100;
    wait_ready("t3_ready", 4'b0100);
    @(negedge clk);
    check("t3_rsp_next", rsp_valid, 1);
    check("t3_no_start", alu_start, 0);
    check("t3_rsp_id", rsp_id, 2);
    check("t3_rsp_result", rsp_result, 0);
    check("t3_rsp_err", rsp_err, 1);
    tick();
    req_valid = '0;
    rsp_ready = 1'b1;
    tick();

    // Backpressure: a result of 100 is held while rsp_ready stays low.
    rsp_ready = 1'b0;
    lat_fixed = 2;
    set_req(3, 60, 40, 3'd0);
    set_req(0, 1, 1, 3'd0);
    req_valid = 4'b1001;
    wait_ready("t4_ready", 4'b1000);
    bad_hold  = 0;
    bad_ready = 0;
    n = 0;
    while (!rsp_valid && n < 50) begin
      @(negedge clk);
      n++;
      if (req_ready != '0) bad_ready++;
    end
    repeat (5) begin
      @(negedge clk);
      if (!rsp_valid || rsp_id != 2'd3 || rsp_result != 100 || rsp_err) bad_hold++;
      if (req_ready != '0) bad_ready++;
    end
    tick();
    rsp_ready = 1'b1;
    @(negedge clk);
    if (!rsp_valid || rsp_result != 100) bad_hold++;
    if (req_ready != '0) bad_ready++;
    @(negedge clk);
    check("t4_next_grant", req_ready, 4'b0001);
    check("t4_hold_stable", bad_hold, 0);
    check("t4_ready_low", bad_ready, 0);
    tick();
    req_valid = '0;
    drain();

    // Reset in BUSY abandons the op, and a late alu_done is ignored.
    drop_done = 1'b1;
    set_req(2, 3, 4, 3'd2);
    req_valid = 4'b0100;
    wait_ready("t5_ready", 4'b0100);
    tick();
    req_valid = '0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!alu_start && n < 20);
    check("t5_started", alu_start, 1);
    tick();
    req_valid = 4'b1001;
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("t5_rst_outputs",
          {req_ready, alu_start, alu_a, alu_b, alu_op, rsp_valid, rsp_id, rsp_result, rsp_err}, 0);
    req_valid = '0;
    drop_done = 1'b0;
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    inj_req++;
    bad_hold = 0;
    repeat (4) begin
      @(negedge clk);
      if (rsp_valid || alu_start) bad_hold++;
    end
    check("t5_no_late_rsp", bad_hold, 0);
    tick();
    req_valid = 4'b1001;
    @(negedge clk);
    check("t5_grant_after_rst", req_ready, 4'b0001);
    tick();
    req_valid = '0;
    rsp_ready = 1'b1;
    drain();

`ifdef CALC_RR_SCHED_TIMEOUT_EN
    // Watchdog: the ALU never answers, so the op times out TOUT cycles after BUSY starts.
    drop_done = 1'b1;
    rsp_ready = 1'b0;
    set_req(1, 5, 6, 3'd0);
    req_valid = 4'b0010;
    wait_ready("t6_ready", 4'b0010);
    tick();
    req_valid = '0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!alu_start && n < 20);
    n = 0;
    while (!rsp_valid && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("t6_timeout_cycles", n, TOUT + 1);
    check("t6_rsp_result", rsp_result, 0);
    check("t6_rsp_err", rsp_err, 1);
    tick();
    rsp_ready = 1'b1;
    drop_done = 1'b0;
    drain();
`endif

    // Randomized traffic with random latency, backpressure and spurious alu_done.
    lat_fixed   = 0;
    spurious_en = 1'b1;
    n_rsp       = 0;
    for (int c = 0; c < 3000; c++) begin
      tick();
      for (int i = 0; i < NREQ; i++) begin
        logic [2:0] op;
        logic [W-1:0] b;
        op = 3'($urandom_range(0, 7));
        if (op == 3'd3 && $urandom_range(0, 3) == 0) b = '0;
        else b = W'($urandom_range(0, 40));
        req_valid[i] = ($urandom_range(0, 3) != 0);
        set_req(i, $urandom, b, op);
      end
      rsp_ready = ($urandom_range(0, 3) != 0);
    end
    tick();
    req_valid   = '0;
    rsp_ready   = 1'b1;
    spurious_en = 1'b0;
    repeat (20) tick();
    check("rand_progress", n_rsp >= 100, 1);
    check("rand_idle_end", {rsp_valid, alu_start, req_ready}, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
